// File: rtl/alu_mc_if.sv
// Handshake and data bundle between operand fetch, the multi-cycle ALU and writeback.
// The master drives operands and the result acknowledge; the slave is the ALU.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [3:0]       aluc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             cout;
   logic             overflow;
   logic             sign;

   modport master (
      output in_valid, src1, src2, aluc, out_ready,
      input  in_ready, out_valid, out, zero, cout, overflow, sign
   );

   modport slave (
      input  in_valid, src1, src2, aluc, out_ready,
      output in_ready, out_valid, out, zero, cout, overflow, sign
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ten single-cycle integer ops, plus iterative multiply and
// restoring divide. Valid/ready handshake on both sides; one op in flight at a time.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      clk,
   input logic      rst_n,
   alu_mc_if.slave  bus
);
   localparam int CW = SHW + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
      OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   state_e           state_q, state_d;
   op_e              op_q, in_op;
   logic [WIDTH-1:0] a_q, b_q, acc_q, out_q;
   logic [CW-1:0]    cnt_q;
   logic             qneg_q, rneg_q, div0_q, dovf_q;
   logic             zero_q, sign_q, cout_q, ovf_q;

   logic             accept, iter_in, last_step, is_mul, signed_div;
   logic [WIDTH:0]   sum_w, dif_w, mul_sum, rem_sh, trial;
   logic [WIDTH-1:0] s_res, f_res, acc_n, b_n, mag1, mag2;
   logic             s_cout, s_ovf, f_ovf;

   assign in_op     = op_e'(bus.aluc);
   assign accept    = bus.in_valid && (state_q == IDLE);
   assign iter_in   = bus.aluc[3] && (bus.aluc[2] || bus.aluc[1]);
   assign last_step = (state_q == BUSY) && (cnt_q == CW'(1));
   assign is_mul    = (op_q[3:1] == 3'b101);

   // Single-cycle results, computed straight from the presented operands.
   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum_w  = {1'b0, bus.src1} + {1'b0, bus.src2};
      dif_w  = {1'b0, bus.src1} - {1'b0, bus.src2};
      s_res  = '0;
      s_cout = 1'b0;
      s_ovf  = 1'b0;
      case (in_op)
         OP_ADD: begin
            s_res  = sum_w[WIDTH-1:0];
            s_cout = sum_w[WIDTH];
            s_ovf  = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (sum_w[WIDTH-1] != bus.src1[WIDTH-1]);
         end
         OP_SUB: begin
            s_res  = dif_w[WIDTH-1:0];
            s_cout = dif_w[WIDTH];
            s_ovf  = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (dif_w[WIDTH-1] != bus.src1[WIDTH-1]);
         end
         OP_AND:  s_res = bus.src1 & bus.src2;
         OP_OR:   s_res = bus.src1 | bus.src2;
         OP_XOR:  s_res = bus.src1 ^ bus.src2;
         OP_SLL:  s_res = bus.src1 << bus.src2[SHW-1:0];
         OP_SRL:  s_res = bus.src1 >> bus.src2[SHW-1:0];
         OP_SRA:  s_res = $signed(bus.src1) >>> bus.src2[SHW-1:0];
         OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
         OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (bus.src1 < bus.src2)};
         default: ;
      endcase
   end

   // Signed divides run on magnitudes; signs are reapplied on the last step.
   always_comb begin
      signed_div = (in_op == OP_DIV) || (in_op == OP_REM);
      mag1 = (signed_div && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
      mag2 = (signed_div && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
   end

   // One iteration: {acc,b} is the product register for MUL, {rem,quotient} for divide.
   always_comb begin
      mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
      rem_sh  = {acc_q, b_q[WIDTH-1]};
      trial   = rem_sh - {1'b0, a_q};
      if (is_mul) begin
         acc_n = mul_sum[WIDTH:1];
         b_n   = {mul_sum[0], b_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         acc_n = trial[WIDTH-1:0];
         b_n   = {b_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_n = rem_sh[WIDTH-1:0];
         b_n   = {b_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      f_res = '0;
      f_ovf = 1'b0;
      case (op_q)
         OP_MUL:   f_res = b_n;
         OP_MULHU: f_res = acc_n;
         OP_DIV: begin
            f_res = div0_q ? '1 : (qneg_q ? -b_n : b_n);
            f_ovf = dovf_q;
         end
         OP_DIVU:  f_res = div0_q ? '1 : b_n;
         OP_REM:   f_res = rneg_q ? -acc_n : acc_n;
         OP_REMU:  f_res = acc_n;
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = iter_in ? BUSY : DONE;
         end
         BUSY: if (cnt_q == CW'(1)) state_d = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block and only acts at an edge.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         dovf_q  <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= in_op;
            cnt_q  <= CW'(WIDTH);
            acc_q  <= '0;
            a_q    <= (bus.aluc[3:1] == 3'b101) ? bus.src1 : mag2;
            b_q    <= (bus.aluc[3:1] == 3'b101) ? bus.src2 : mag1;
            qneg_q <= bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1];
            rneg_q <= bus.src1[WIDTH-1];
            div0_q <= (bus.src2 == '0);
            dovf_q <= (bus.src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.src2 == '1);
            if (!iter_in) begin
               out_q  <= s_res;
               zero_q <= (s_res == '0);
               sign_q <= s_res[WIDTH-1];
               cout_q <= s_cout;
               ovf_q  <= s_ovf;
            end
         end else if (state_q == BUSY) begin
            acc_q <= acc_n;
            b_q   <= b_n;
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
               out_q  <= f_res;
               zero_q <= (f_res == '0);
               sign_q <= f_res[WIDTH-1];
               cout_q <= 1'b0;
               ovf_q  <= f_ovf;
            end
         end
      end
   end

   assign bus.out      = out_q;
   assign bus.zero     = zero_q;
   assign bus.sign     = sign_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes model results at accept, a negedge
// monitor pops and compares each result, its flags, latency and hold stability.
module tb_alu_mc;
   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_mc_if #(.WIDTH(W)) bus ();
   alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [W-1:0] a, b, res;
      logic [3:0]   op;
      logic         cout, ovf;
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_tests = 0, n_fail = 0, cyc = 0;
   logic mon_en = 1'b0, prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference semantics from plain 64-bit integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                 output logic [W-1:0] res, output logic cout, output logic ovf);
      longint sa, sbv, s;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = {32'b0, a} * {32'b0, b};
      res = '0; cout = 1'b0; ovf = 1'b0; s = 0;
      case (op)
         4'd0: begin s = sa + sbv; res = s[W-1:0]; cout = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF; ovf = (s > MAXS) || (s < MINS); end
         4'd1: begin s = sa - sbv; res = s[W-1:0]; cout = (a < b); ovf = (s > MAXS) || (s < MINS); end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = a << b[4:0];
         4'd6: res = a >> b[4:0];
         4'd7: res = $signed(a) >>> b[4:0];
         4'd8: res = {31'b0, ($signed(a) < $signed(b))};
         4'd9: res = {31'b0, (a < b)};
         4'd10: res = p[31:0];
         4'd11: res = p[63:32];
         4'd12: begin
            if (b == '0) res = '1;
            else if (a == MIN && b == '1) begin res = MIN; ovf = 1'b1; end
            else begin s = sa / sbv; res = s[W-1:0]; end
         end
         4'd13: res = (b == '0) ? '1 : a / b;
         4'd14: begin
            if (b == '0) res = a;
            else if (a == MIN && b == '1) res = '0;
            else begin s = sa % sbv; res = s[W-1:0]; end
         end
         default: res = (b == '0) ? a : a % b;
      endcase
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               cur = sb.pop_front();
               check($sformatf("out op=%0d a=%h b=%h", cur.op, cur.a, cur.b), bus.out, cur.res);
               check($sformatf("flags{z,s,c,v} op=%0d a=%h b=%h", cur.op, cur.a, cur.b),
                     32'({bus.zero, bus.sign, bus.cout, bus.overflow}),
                     32'({(cur.res == '0), cur.res[W-1], cur.cout, cur.ovf}));
               check($sformatf("latency op=%0d", cur.op), 32'(cyc - cur.acc_cyc + 1),
                     (cur.op >= 4'd10) ? 32'(W + 1) : 32'd1);
            end
         end else if (bus.out_valid) begin
            check("hold_out_stable", bus.out, cur.res);
            check("hold_in_ready_low", 32'(bus.in_ready), 32'd0);
         end
      end
      prev_ov = bus.out_valid;
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      exp_t e;
      int   t;
      logic low_ok;
      t = 0;
      while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.aluc = op; bus.src1 = a; bus.src2 = b;
      e.a = a; e.b = b; e.op = op; e.acc_cyc = cyc + 1;
      model(op, a, b, e.res, e.cout, e.ovf);
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.src1 = $urandom; bus.src2 = $urandom; bus.aluc = 4'($urandom);
      t = 0; low_ok = 1'b1;
      while (!bus.out_valid && t < 2 * W) begin
         if (bus.in_ready) low_ok = 1'b0;
         @(negedge clk); t++;
      end
      check("out_valid_wait", 32'(bus.out_valid), 32'd1);
      if (op >= 4'd10) check("busy_in_ready_low", 32'(low_ok), 32'd1);
      bus.in_valid = (hold > 0);
      repeat (hold) @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("idle_after_release{in_ready,out_valid}", 32'({bus.in_ready, bus.out_valid}), 32'b10);
   endtask

   task automatic abort_test();
      logic seen;
      int   t;
      t = 0;
      while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
      bus.in_valid = 1'b1; bus.aluc = 4'd10; bus.src1 = $urandom; bus.src2 = $urandom;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_reset{rdy,ov,z,c,v,s}",
            32'({bus.in_ready, bus.out_valid, bus.zero, bus.cout, bus.overflow, bus.sign}), 32'b100000);
      check("abort_reset_out", bus.out, 32'd0);
      seen = 1'b0;
      repeat (W + 5) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.src1 = '0; bus.src2 = '0; bus.aluc = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset{rdy,ov,z,c,v,s}",
            32'({bus.in_ready, bus.out_valid, bus.zero, bus.cout, bus.overflow, bus.sign}), 32'b100000);
      check("reset_out", bus.out, 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      issue(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
      issue(4'd1,  32'h8000_0000, 32'h0000_0001, 0);
      issue(4'd7,  32'h8000_0000, 32'h0000_0004, 0);
      issue(4'd10, 32'h0001_0000, 32'h0001_0000, 0);
      issue(4'd11, 32'h0001_0000, 32'h0001_0000, 0);
      issue(4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(4'd13, 32'd100, 32'd7, 0);
      issue(4'd15, 32'd100, 32'd7, 5);
      issue(4'd12, MIN, 32'hFFFF_FFFF, 0);
      issue(4'd14, MIN, 32'hFFFF_FFFF, 0);
      issue(4'd13, 32'd5, 32'd0, 0);
      issue(4'd15, 32'd5, 32'd0, 0);
      issue(4'd12, 32'hFFFF_FFF9, 32'd0, 0);
      issue(4'd14, 32'hFFFF_FFF9, 32'd0, 0);
      issue(4'd1,  32'd3, 32'd5, 5);

      abort_test();

      for (int i = 0; i < 150; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         int           k;
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         k  = $urandom_range(0, 9);
         if (k == 0) b = '0;
         else if (k == 1) begin a = MIN; b = '1; end
         else if (k == 2) b = W'($urandom_range(0, 40));
         else if (k == 3) a = W'($urandom_range(0, 40));
         issue(op, a, b, $urandom_range(0, 2));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing ten integer ops in one cycle, plus iterative multiply, divide and remainder.
- Uses a valid/ready handshake on both input and output.
- Sits between the operand-fetch stage and writeback; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block can accept an op.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B; shift amount is src2[SHW-1:0].
- aluc  input  4  op code.
- out_valid  output  1  result and flags held valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- cout  output  1  carry (ADD) or borrow (SUB); 0 otherwise.
- overflow  output  1  signed overflow (ADD/SUB, DIV MIN/-1); 0 otherwise.
- sign  output  1  out[WIDTH-1].

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out=0, all flags 0. Any in-flight op is discarded.
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- ADD/SUB arithmetic: computed at WIDTH+1 bits; cout = bit WIDTH of {0,src1}±{0,src2}, so SUB cout=1 iff src1<src2 unsigned.
- ADD/SUB overflow: ADD: src1 and src2 share a sign and out's sign differs. SUB: src1 and src2 differ in sign and out's sign differs from src1.
- Accept: handshake fires when in_valid & in_ready at a clk edge. Operands and op are captured there; later input changes are ignored.
- States:
  - IDLE: in_ready=1. Single-cycle op accepted → DONE. Ops 1010–1111 accepted → BUSY with iteration counter = WIDTH.
  - BUSY: in_ready=0, out_valid=0. One shift-add (MUL) or restoring-subtract (DIV family) step per cycle; counter decrements. When the counter reaches 0 → DONE.
  - DONE: out_valid=1, in_ready=0. out and flags are stable. On out_ready=1 → IDLE.
- Latency:
  - Single-cycle ops: out_valid rises on the edge after accept.
  - Mul/div: out_valid rises WIDTH+1 edges after accept.
  - Initiation interval ≥ latency+1, since in_ready is only asserted in IDLE.
- Signed divide: operand magnitudes are divided unsigned. Quotient sign = sign(src1) XOR sign(src2). Remainder takes the sign of src1.
- Divide by zero, detected at accept, still takes the full WIDTH+1 cycles:
  - DIV/DIVU: out = all ones.
  - REM/REMU: out = src1.
  - overflow = 0.
- Signed overflow (DIV/REM with src1 = MIN, src2 = −1):
  - DIV: out = MIN, overflow = 1.
  - REM: out = 0, overflow = 0.
- Flags: zero and sign are derived from the final registered out for every op. cout and overflow are 0 except as defined above.
- Backpressure: while out_ready=0 in DONE, out and flags hold indefinitely. in_valid is ignored.
- Reset mid-BUSY or mid-DONE: abort, return to IDLE; no out_valid pulse follows.
- Idle outputs: out and flags keep the last result in IDLE; only out_valid qualifies them.

Test Plan:
- Reset then ADD 0xFFFFFFFF+0x00000001 → one cycle later out_valid=1, out=0, zero=1, cout=1, overflow=0.
- SUB 0x80000000−0x00000001 → out=0x7FFFFFFF, overflow=1, cout=0, sign=0. SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0x0001_0000×0x0001_0000 → out=0 after 33 cycles. MULHU same operands → out=0x00000001. in_ready=0 throughout BUSY.
- DIV 0xFFFFFFF9(−7)÷2 → 0xFFFFFFFD(−3). REM same operands → 0xFFFFFFFF(−1). DIVU 100÷7 → 14. REMU 100÷7 → 2.
- DIV 0x80000000÷0xFFFFFFFF → out=0x80000000, overflow=1. DIVU 5÷0 → 0xFFFFFFFF. REMU 5÷0 → 5.
- Control sequence:
  - Hold out_ready=0 for 5 cycles in DONE → out stable, in_ready=0; release → IDLE next edge.
  - Assert rst_n=0 at BUSY cycle 10 → IDLE, out_valid never rises.
